// File: rtl/ppfifo_axi_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ppfifo_axi_stream_arbiter
// Description : Round-robin arbiter streaming whole ping-pong FIFO blocks
//               from two read ports onto one AXI Stream master.
// Revision    : 1.0  initial release
// ============================================================================
module ppfifo_axi_stream_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_axi_clk,
    input  logic                  rst,
    input  logic [1:0]            i_enable,

    input  logic                  i_p0_rdy,
    output logic                  o_p0_act,
    input  logic [23:0]           i_p0_size,
    input  logic [DATA_WIDTH-1:0] i_p0_data,
    output logic                  o_p0_stb,

    input  logic                  i_p1_rdy,
    output logic                  o_p1_act,
    input  logic [23:0]           i_p1_size,
    input  logic [DATA_WIDTH-1:0] i_p1_data,
    output logic                  o_p1_stb,

    output logic                  o_axi_valid,
    input  logic                  i_axi_ready,
    output logic [DATA_WIDTH-1:0] o_axi_data,
    output logic                  o_axi_last,
    output logic                  o_axi_user,
    output logic                  o_axi_id,
    output logic                  o_busy
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_grant   = 2'd1;
    localparam logic [1:0] c_st_stream  = 2'd2;
    localparam logic [1:0] c_st_release = 2'd3;

    logic [1:0]  r_state;
    logic        r_grant;
    logic        r_last_grant;
    logic [23:0] r_size;
    logic [23:0] r_count;
    logic [1:0]  r_act;

    logic [1:0]  w_cand;
    logic        w_sel;
    logic        w_streaming;
    logic        w_last;
    logic        w_hs;

    always_comb begin
        w_cand[0]   = i_p0_rdy & i_enable[0] & ~r_act[0];
        w_cand[1]   = i_p1_rdy & i_enable[1] & ~r_act[1];
        // On contention the port that did not win last time goes next
        w_sel       = w_cand[0] ? (w_cand[1] & ~r_last_grant) : 1'b1;
        w_streaming = (r_state == c_st_stream) & ~rst;
        w_last      = (r_count == (r_size - 24'd1));
        w_hs        = w_streaming & i_axi_ready;
    end

    assign o_p0_act    = r_act[0];
    assign o_p1_act    = r_act[1];
    assign o_p0_stb    = w_hs & ~r_grant;
    assign o_p1_stb    = w_hs & r_grant;
    assign o_axi_valid = w_streaming;
    assign o_axi_data  = r_grant ? i_p1_data : i_p0_data;
    assign o_axi_last  = w_streaming & w_last;
    assign o_axi_user  = w_streaming & (r_count == 24'd0);
    assign o_axi_id    = w_streaming & r_grant;
    assign o_busy      = (r_state != c_st_idle) & ~rst;

    always_ff @(posedge i_axi_clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_size       <= 24'd0;
            r_count      <= 24'd0;
            r_act        <= 2'b00;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (|w_cand) begin
                        r_grant  <= w_sel;
                        r_size   <= w_sel ? i_p1_size : i_p0_size;
                        r_count  <= 24'd0;
                        r_act    <= w_sel ? 2'b10 : 2'b01;
                        r_state  <= c_st_grant;
                    end
                end
                c_st_grant: begin
                    // Zero-length blocks are activated and released without a beat
                    if (r_size == 24'd0) begin
                        r_act   <= 2'b00;
                        r_state <= c_st_release;
                    end else begin
                        r_state <= c_st_stream;
                    end
                end
                c_st_stream: begin
                    if (w_hs) begin
                        r_count <= r_count + 24'd1;
                        if (w_last) begin
                            r_act   <= 2'b00;
                            r_state <= c_st_release;
                        end
                    end
                end
                default: begin
                    r_last_grant <= r_grant;
                    r_state      <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ppfifo_axi_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ppfifo_axi_stream_arbiter
// Description : Directed self-checking bench for ppfifo_axi_stream_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ppfifo_axi_stream_arbiter;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    i_enable = 2'b11;
    logic          i_p0_rdy = 1'b0;
    logic          o_p0_act;
    logic [23:0]   i_p0_size = 24'd0;
    logic [DW-1:0] i_p0_data = '0;
    logic          o_p0_stb;
    logic          i_p1_rdy = 1'b0;
    logic          o_p1_act;
    logic [23:0]   i_p1_size = 24'd0;
    logic [DW-1:0] i_p1_data = '0;
    logic          o_p1_stb;
    logic          o_axi_valid;
    logic          i_axi_ready = 1'b1;
    logic [DW-1:0] o_axi_data;
    logic          o_axi_last;
    logic          o_axi_user;
    logic          o_axi_id;
    logic          o_busy;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [1:0]    act_seen = 2'b00;

    always #5 clk = ~clk;

    ppfifo_axi_stream_arbiter #(.DATA_WIDTH(DW)) dut (
        .i_axi_clk   (clk),
        .rst         (rst),
        .i_enable    (i_enable),
        .i_p0_rdy    (i_p0_rdy),
        .o_p0_act    (o_p0_act),
        .i_p0_size   (i_p0_size),
        .i_p0_data   (i_p0_data),
        .o_p0_stb    (o_p0_stb),
        .i_p1_rdy    (i_p1_rdy),
        .o_p1_act    (o_p1_act),
        .i_p1_size   (i_p1_size),
        .i_p1_data   (i_p1_data),
        .o_p1_stb    (o_p1_stb),
        .o_axi_valid (o_axi_valid),
        .i_axi_ready (i_axi_ready),
        .o_axi_data  (o_axi_data),
        .o_axi_last  (o_axi_last),
        .o_axi_user  (o_axi_user),
        .o_axi_id    (o_axi_id),
        .o_busy      (o_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        act_seen = act_seen | {o_p1_act, o_p0_act};
    endtask

    task automatic wait_valid(output int gap);
        gap = 0;
        while (!o_axi_valid && gap < 40) begin
            step();
            gap++;
        end
        if (!o_axi_valid) check("valid_timeout", 32'(o_axi_valid), 32'd1);
    endtask

    // Drives the granted port's FIFO data and checks each cycle of a block
    task automatic stream_block(input int port, input int size, input int nbeats,
                                input logic [31:0] base, input logic [7:0] pat);
        int   beat = 0;
        int   k    = 0;
        int   stbs = 0;
        logic rdy;
        while (beat < nbeats && k < 64) begin
            rdy = pat[k % 8];
            i_axi_ready = rdy;
            if (port == 0) begin
                i_p0_data = base + 32'(beat);
                i_p1_data = 32'hDEAD0000 + 32'(k);
            end else begin
                i_p1_data = base + 32'(beat);
                i_p0_data = 32'hBEEF0000 + 32'(k);
            end
            #1;
            check("valid", 32'(o_axi_valid), 32'd1);
            check("data",  o_axi_data, base + 32'(beat));
            check("id",    32'(o_axi_id), 32'(port));
            check("user",  32'(o_axi_user), 32'(beat == 0));
            check("last",  32'(o_axi_last), 32'(beat == size - 1));
            check("stb0",  32'(o_p0_stb), 32'(rdy && port == 0));
            check("stb1",  32'(o_p1_stb), 32'(rdy && port == 1));
            stbs += int'(o_p0_stb) + int'(o_p1_stb);
            if (rdy) beat++;
            k++;
            step();
        end
        i_axi_ready = 1'b1;
        check("stb_count", 32'(stbs), 32'(nbeats));
        if (nbeats == size) begin
            check("rel_act",   32'(port == 1 ? o_p1_act : o_p0_act), 32'd0);
            check("rel_valid", 32'(o_axi_valid), 32'd0);
        end
    endtask

    initial begin
        int gap;

        // Reset values
        step();
        step();
        check("rst_outs", 32'({o_p0_act, o_p1_act, o_p0_stb, o_p1_stb, o_axi_valid,
                               o_axi_last, o_axi_user, o_axi_id, o_busy}), 32'd0);
        rst = 1'b0;
        step();

        // Port 0 alone, size 4
        act_seen  = 2'b00;
        i_p0_size = 24'd4;
        i_p0_rdy  = 1'b1;
        step();
        check("grant_act",   32'(o_p0_act), 32'd1);
        check("grant_valid", 32'(o_axi_valid), 32'd0);
        check("grant_busy",  32'(o_busy), 32'd1);
        i_p0_rdy = 1'b0;
        step();
        check("first_valid", 32'(o_axi_valid), 32'd1);
        stream_block(0, 4, 4, 32'hA0, 8'hFF);
        check("p1_idle", 32'(act_seen[1]), 32'd0);

        // Both ports ready, size 3: alternate 0,1,0,1 with a 3-cycle gap
        rst = 1'b1;
        step();
        rst = 1'b0;
        i_p0_size = 24'd3;
        i_p1_size = 24'd3;
        i_p0_rdy  = 1'b1;
        i_p1_rdy  = 1'b1;
        wait_valid(gap);
        for (int i = 0; i < 4; i++) begin
            stream_block(i % 2, 3, 3, 32'h100 * 32'(i + 1), 8'hFF);
            if (i < 3) begin
                wait_valid(gap);
                check("rr_gap", 32'(gap), 32'd3);
            end
        end
        i_p0_rdy = 1'b0;
        i_p1_rdy = 1'b0;

        // Port 1, size 5, with back-pressure
        step();
        i_p1_size = 24'd5;
        i_p1_rdy  = 1'b1;
        wait_valid(gap);
        i_p1_rdy = 1'b0;
        stream_block(1, 5, 5, 32'hC0, 8'b1101_1001);

        // Zero-size block on port 1, then port 0 size 2
        step();
        step();
        i_p1_size = 24'd0;
        i_p1_rdy  = 1'b1;
        step();
        check("zero_act",   32'(o_p1_act), 32'd1);
        check("zero_valid", 32'(o_axi_valid), 32'd0);
        i_p1_rdy = 1'b0;
        step();
        check("zero_rel_act",   32'(o_p1_act), 32'd0);
        check("zero_rel_valid", 32'(o_axi_valid), 32'd0);
        i_p0_size = 24'd2;
        i_p0_rdy  = 1'b1;
        wait_valid(gap);
        i_p0_rdy = 1'b0;
        stream_block(0, 2, 2, 32'hE0, 8'hFF);

        // Reset after 2 of 8 beats on port 0
        i_p0_size = 24'd8;
        i_p0_rdy  = 1'b1;
        wait_valid(gap);
        i_p0_rdy = 1'b0;
        stream_block(0, 8, 2, 32'hF0, 8'hFF);
        rst = 1'b1;
        step();
        check("rst_mid", 32'({o_p0_act, o_p1_act, o_p0_stb, o_p1_stb, o_axi_valid}), 32'd0);
        rst = 1'b0;
        i_p0_size = 24'd1;
        i_p1_size = 24'd1;
        i_p0_rdy  = 1'b1;
        i_p1_rdy  = 1'b1;
        wait_valid(gap);
        stream_block(0, 1, 1, 32'h50, 8'hFF);
        i_p0_rdy = 1'b0;
        i_p1_rdy = 1'b0;

        // Port 1 masked off: port 0 back-to-back
        step();
        step();
        step();
        act_seen  = 2'b00;
        i_enable  = 2'b01;
        i_p0_size = 24'd2;
        i_p1_size = 24'd2;
        i_p0_rdy  = 1'b1;
        i_p1_rdy  = 1'b1;
        wait_valid(gap);
        for (int i = 0; i < 3; i++) begin
            stream_block(0, 2, 2, 32'h700 + 32'h10 * 32'(i), 8'hFF);
            if (i < 2) begin
                wait_valid(gap);
                check("mask_gap", 32'(gap), 32'd3);
            end
        end
        i_p0_rdy = 1'b0;
        i_p1_rdy = 1'b0;
        check("p1_masked", 32'(act_seen[1]), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
